// File: rtl/snake_body_streamer_if.sv
// Serial body interface between the game-logic body store and the renderer.
// It also carries the move request and move status signals. The streamer uses master; the game FSM and renderer use slave.
interface snake_body_streamer_if #(
    parameter int SNAKE_LENGTH_BIT = 7
);
    logic                        move_tick;
    logic                        grow;
    logic [6:0]                  head_x;
    logic [6:0]                  head_y;
    logic [6:0]                  next_head_x;
    logic [6:0]                  next_head_y;
    logic [SNAKE_LENGTH_BIT-1:0] body_count;
    logic [6:0]                  snake_body_x;
    logic [6:0]                  snake_body_y;
    logic [SNAKE_LENGTH_BIT-1:0] snake_length;
    logic                        shift_busy;
    logic                        move_done;
    logic                        self_hit;
    logic                        grow_ignored;

    modport master (
        input  move_tick, grow, head_x, head_y, next_head_x, next_head_y,
        output body_count, snake_body_x, snake_body_y, snake_length,
        output shift_busy, move_done, self_hit, grow_ignored
    );

    modport slave (
        output move_tick, grow, head_x, head_y, next_head_x, next_head_y,
        input  body_count, snake_body_x, snake_body_y, snake_length,
        input  shift_busy, move_done, self_hit, grow_ignored
    );
endinterface

// File: rtl/snake_body_streamer.sv
// Snake body segment store. It shifts and grows the body on each move tick and detects self-collision.
// It streams one segment per clock to the renderer. Option macro BODY_STREAM_ACTIVE_ONLY_EN limits streaming to the live entries.
module snake_body_streamer #(
    parameter int SNAKE_LENGTH_BIT = 7,
    parameter int SNAKE_LENGTH_MAX = 2 ** SNAKE_LENGTH_BIT,
    parameter int INIT_LENGTH      = 3,
    parameter int INIT_X           = 60,
    parameter int INIT_Y           = 40
) (
    input  logic                   clock_25,
    input  logic                   reset,
    snake_body_streamer_if.master  bus
);
    localparam int DEPTH = SNAKE_LENGTH_MAX - 1;
    localparam logic [SNAKE_LENGTH_BIT-1:0] ONE       = SNAKE_LENGTH_BIT'(1);
    localparam logic [SNAKE_LENGTH_BIT-1:0] LEN_LIMIT = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 1);

    typedef enum logic [1:0] {STREAM, SHIFT, DONE} state_t;

    state_t                      state;
    logic [6:0]                  body_x [0:DEPTH-1];
    logic [6:0]                  body_y [0:DEPTH-1];
    logic [SNAKE_LENGTH_BIT-1:0] idx;
    logic [6:0]                  head_x_l, head_y_l, next_x_l, next_y_l;
    logic                        grow_req, grow_eff, hit;

    logic [SNAKE_LENGTH_BIT-1:0] body_count, snake_length, stream_next;
    logic [6:0]                  out_x, out_y, shift_x, shift_y;
    logic                        shift_busy, move_done, self_hit, grow_ignored;
    logic                        grow_ok, shift_match;

    assign bus.body_count   = body_count;
    assign bus.snake_body_x = out_x;
    assign bus.snake_body_y = out_y;
    assign bus.snake_length = snake_length;
    assign bus.shift_busy   = shift_busy;
    assign bus.move_done    = move_done;
    assign bus.self_hit     = self_hit;
    assign bus.grow_ignored = grow_ignored;

    assign grow_ok = bus.grow && (snake_length < LEN_LIMIT);

`ifdef BODY_STREAM_ACTIVE_ONLY_EN
    always_comb begin
        stream_next = body_count + ONE;
        if (body_count >= snake_length - ONE) begin
            stream_next = '0;
        end
    end
`else
    localparam logic [SNAKE_LENGTH_BIT-1:0] LAST_IDX = SNAKE_LENGTH_BIT'(SNAKE_LENGTH_MAX - 2);

    always_comb begin
        stream_next = body_count + ONE;
        if (body_count == LAST_IDX) begin
            stream_next = '0;
        end
    end
`endif

    // The value written this step is both the new entry and what goes out on the stream.
    // Non-zero indices read the pre-shift entry idx-1, so the collision check sees every surviving segment.
    always_comb begin
        shift_x = head_x_l;
        shift_y = head_y_l;
        if (idx != '0) begin
            shift_x = body_x[idx - ONE];
            shift_y = body_y[idx - ONE];
        end
        shift_match = (idx != '0) && (shift_x == next_x_l) && (shift_y == next_y_l);
    end

    always_ff @(posedge clock_25 or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                body_x[i] <= (i < INIT_LENGTH) ? 7'(INIT_X - 1 - i) : 7'd0;
                body_y[i] <= (i < INIT_LENGTH) ? 7'(INIT_Y) : 7'd0;
            end
            state        <= STREAM;
            idx          <= '0;
            head_x_l     <= '0;
            head_y_l     <= '0;
            next_x_l     <= '0;
            next_y_l     <= '0;
            grow_req     <= 1'b0;
            grow_eff     <= 1'b0;
            hit          <= 1'b0;
            body_count   <= '0;
            out_x        <= 7'(INIT_X - 1);
            out_y        <= 7'(INIT_Y);
            snake_length <= SNAKE_LENGTH_BIT'(INIT_LENGTH);
            shift_busy   <= 1'b0;
            move_done    <= 1'b0;
            self_hit     <= 1'b0;
            grow_ignored <= 1'b0;
        end else begin
            move_done    <= 1'b0;
            self_hit     <= 1'b0;
            grow_ignored <= 1'b0;
            case (state)
                STREAM: begin
                    body_count <= stream_next;
                    out_x      <= body_x[stream_next];
                    out_y      <= body_y[stream_next];
                    if (bus.move_tick) begin
                        head_x_l   <= bus.head_x;
                        head_y_l   <= bus.head_y;
                        next_x_l   <= bus.next_head_x;
                        next_y_l   <= bus.next_head_y;
                        grow_req   <= bus.grow;
                        grow_eff   <= grow_ok;
                        idx        <= grow_ok ? snake_length : snake_length - ONE;
                        hit        <= 1'b0;
                        shift_busy <= 1'b1;
                        state      <= SHIFT;
                    end
                end
                SHIFT: begin
                    body_x[idx] <= shift_x;
                    body_y[idx] <= shift_y;
                    body_count  <= idx;
                    out_x       <= shift_x;
                    out_y       <= shift_y;
                    if (shift_match) begin
                        hit <= 1'b1;
                    end
                    if (idx == '0) begin
                        state <= DONE;
                    end else begin
                        idx <= idx - ONE;
                    end
                end
                DONE: begin
                    move_done    <= 1'b1;
                    self_hit     <= hit;
                    grow_ignored <= grow_req & ~grow_eff;
                    snake_length <= snake_length + SNAKE_LENGTH_BIT'(grow_eff);
                    shift_busy   <= 1'b0;
                    body_count   <= '0;
                    out_x        <= body_x[0];
                    out_y        <= body_y[0];
                    state        <= STREAM;
                end
                default: state <= STREAM;
            endcase
        end
    end
endmodule
